mem_readback_engine: RTL and testbench

- Read-side counterpart to the capture write arbiter: fetches captured data out of DDR3 through the MIG user interface for host/readout logic.
- Accepts one request (start address + burst count), issues MIG READ commands for consecutive 64-byte bursts, and collects app_rd_data beats.
- Delivers the beats as a 256-bit valid/ready stream, never issuing a read it cannot buffer.
- Sits in the clk_ram domain alongside the write arbiter; the shared app_* command port is muxed outside this block.

---
 rtl/mem_pkg.sv | 17 +
 rtl/sync_fifo_fwft.sv | 69 ++++++
 rtl/mem_readback_engine.sv | 198 +++++++++++++++++++
 tb/tb_mem_readback_engine.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared DDR3/MIG user-interface definitions for the capture write arbiter
// and the read-back engine.
package mem_pkg;

    localparam int unsigned APP_ADDR_W = 29;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    // Read-back engine control states
    typedef enum logic [1:0] {
        RB_IDLE  = 2'd0,
        RB_ISSUE = 2'd1,
        RB_DRAIN = 2'd2
    } rb_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through buffer. rd_data_o shows the head word
// whenever empty_o is low; writes while full are ignored.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_s, pop_s, full_s, empty_s;

    // Pointer and occupancy next-state; push and pop together keep the count
    always_comb begin
        full_s   = (count_q == FULL_CNT);
        empty_s  = (count_q == {(PTR_W + 1){1'b0}});
        push_s   = wr_en_i && !full_s;
        pop_s    = rd_en_i && !empty_s;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are qualified by the pointers so need no reset
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = empty_s;
    assign full_o    = full_s;
    assign count_o   = count_q;

endmodule

// File: rtl/mem_readback_engine.sv
// Read-back engine: turns one (address, burst count) request into MIG READ
// commands, buffers the returned beats and streams them out. A command is only
// issued when buffer space for it and every burst still in flight is reserved.
module mem_readback_engine
    import mem_pkg::*;
#(
    parameter int unsigned BUF_DEPTH       = 64,
    parameter int unsigned ADDR_STEP       = 8,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                  clk_ram,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [APP_ADDR_W-1:0] req_addr,
    input  logic [15:0]           req_bursts,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    input  logic [255:0]          app_rd_data,
    input  logic                  app_rd_data_end,
    input  logic                  app_rd_data_valid,
    output logic [255:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_overflow
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [APP_ADDR_W-1:0] ADDR_STEP_C = APP_ADDR_W'(ADDR_STEP);
    localparam logic [OUT_W-1:0]      OUT_ONE     = {{(OUT_W - 1){1'b0}}, 1'b1};

    rb_state_e             state_q, state_d;
    logic                  app_en_q, app_en_d;
    logic [APP_ADDR_W-1:0] app_addr_q, app_addr_d;
    logic [2:0]            app_cmd_q, app_cmd_d;
    logic [15:0]           issue_left_q, issue_left_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic [16:0]           beat_cnt_q, beat_cnt_d;
    logic [16:0]           beat_total_q, beat_total_d;
    logic                  err_overflow_q, err_overflow_d;

    logic                  accept_s, ret_push_s, ret_end_s, pop_s;
    logic                  fifo_empty_s, fifo_full_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [31:0]           occ_next_s, free_next_s, need_s;
    logic                  credit_ok_s;

    // Beats are only taken while a request is active, so data from commands
    // issued before a reset is dropped silently.
    assign accept_s   = app_en_q && app_rdy;
    assign ret_push_s = app_rd_data_valid && (state_q != RB_IDLE);
    assign ret_end_s  = ret_push_s && app_rd_data_end;
    assign pop_s      = !fifo_empty_s && out_ready;

    sync_fifo_fwft #(
        .WIDTH (256),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i     (clk_ram),
        .rst_i     (rst),
        .wr_en_i   (ret_push_s),
        .wr_data_i (app_rd_data),
        .rd_en_i   (pop_s),
        .rd_data_o (out_data),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s),
        .count_o   (fifo_count_s)
    );

    // Bursts in flight: up on command accept, down on the last beat of a burst
    always_comb begin
        case ({accept_s, ret_end_s && (outstanding_q != {OUT_W{1'b0}})})
            2'b10:   outstanding_d = outstanding_q + OUT_ONE;
            2'b01:   outstanding_d = outstanding_q - OUT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Credit check against next-cycle occupancy and outstanding count
    always_comb begin
        occ_next_s  = 32'(fifo_count_s)
                    + ((ret_push_s && !fifo_full_s) ? 32'd1 : 32'd0)
                    - (pop_s ? 32'd1 : 32'd0);
        free_next_s = 32'(BUF_DEPTH) - occ_next_s;
        need_s      = 32'd2 * (32'(outstanding_d) + 32'd1);
        credit_ok_s = (free_next_s >= need_s)
                    && (32'(outstanding_d) < 32'(MAX_OUTSTANDING));
    end

    // Control FSM next-state and command/beat bookkeeping
    always_comb begin
        state_d        = state_q;
        app_en_d       = app_en_q;
        app_addr_d     = app_addr_q;
        issue_left_d   = issue_left_q;
        beat_total_d   = beat_total_q;
        beat_cnt_d     = beat_cnt_q;
        err_overflow_d = err_overflow_q | (ret_push_s && fifo_full_s);

        if (accept_s) begin
            app_addr_d   = app_addr_q + ADDR_STEP_C;
            issue_left_d = issue_left_q - 16'd1;
        end else begin
            app_addr_d   = app_addr_q;
            issue_left_d = issue_left_q;
        end

        if (pop_s) begin
            beat_cnt_d = beat_cnt_q + 17'd1;
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        case (state_q)
            RB_IDLE: begin
                app_en_d = 1'b0;
                if (req_valid && (req_bursts != 16'd0)) begin
                    state_d      = RB_ISSUE;
                    app_en_d     = 1'b1;
                    app_addr_d   = req_addr;
                    issue_left_d = req_bursts;
                    beat_total_d = {req_bursts, 1'b0};
                    beat_cnt_d   = 17'd0;
                end else begin
                    state_d = RB_IDLE;
                end
            end
            RB_ISSUE: begin
                if (app_en_q && !app_rdy) begin
                    app_en_d = 1'b1;
                end else if (issue_left_d == 16'd0) begin
                    app_en_d = 1'b0;
                    state_d  = RB_DRAIN;
                end else begin
                    app_en_d = credit_ok_s;
                end
            end
            RB_DRAIN: begin
                app_en_d = 1'b0;
                if ((outstanding_q == {OUT_W{1'b0}}) && fifo_empty_s) begin
                    state_d = RB_IDLE;
                end else begin
                    state_d = RB_DRAIN;
                end
            end
            default: begin
                app_en_d = 1'b0;
                state_d  = RB_IDLE;
            end
        endcase

        if (app_en_d) begin
            app_cmd_d = MIG_CMD_READ;
        end else begin
            app_cmd_d = 3'b000;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_ram) begin
        if (rst) begin
            state_q        <= RB_IDLE;
            app_en_q       <= 1'b0;
            app_addr_q     <= {APP_ADDR_W{1'b0}};
            app_cmd_q      <= 3'b000;
            issue_left_q   <= 16'd0;
            outstanding_q  <= {OUT_W{1'b0}};
            beat_cnt_q     <= 17'd0;
            beat_total_q   <= 17'd0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            app_en_q       <= app_en_d;
            app_addr_q     <= app_addr_d;
            app_cmd_q      <= app_cmd_d;
            issue_left_q   <= issue_left_d;
            outstanding_q  <= outstanding_d;
            beat_cnt_q     <= beat_cnt_d;
            beat_total_q   <= beat_total_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign app_en       = app_en_q;
    assign app_addr     = app_addr_q;
    assign app_cmd      = app_cmd_q;
    assign out_valid    = !fifo_empty_s;
    assign out_last     = !fifo_empty_s && (beat_cnt_q == (beat_total_q - 17'd1));
    assign busy         = (state_q != RB_IDLE);
    assign req_ready    = (state_q == RB_IDLE);
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_mem_readback_engine.sv
// Bench for mem_readback_engine: a MIG responder returns two tagged beats per
// accepted READ after a fixed latency; a request-level model predicts the
// command address list and the output word stream.
module tb_mem_readback_engine;

    localparam int BUF_DEPTH = 8;
    localparam int LAT       = 5;

    logic          clk_ram = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [28:0]   req_addr = 29'd0;
    logic [15:0]   req_bursts = 16'd0;
    logic [28:0]   app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy = 1'b0;
    logic [255:0]  app_rd_data = 256'd0;
    logic          app_rd_data_end = 1'b0;
    logic          app_rd_data_valid = 1'b0;
    logic [255:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          err_overflow;

    always #5 clk_ram = ~clk_ram;

    mem_readback_engine #(
        .BUF_DEPTH       (BUF_DEPTH),
        .ADDR_STEP       (8),
        .MAX_OUTSTANDING (16)
    ) dut (
        .clk_ram           (clk_ram),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_bursts        (req_bursts),
        .app_addr          (app_addr),
        .app_cmd           (app_cmd),
        .app_en            (app_en),
        .app_rdy           (app_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_end   (app_rd_data_end),
        .app_rd_data_valid (app_rd_data_valid),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .busy              (busy),
        .err_overflow      (err_overflow)
    );

    typedef struct {
        logic [255:0] d;
        bit           e;
        int           due;
    } beat_t;

    typedef struct {
        logic [28:0] addr;
        int          bursts;
        int          rdy_pct;
        int          ordy_pct;
        int          exp_cmds;
        int          exp_words;
        int          exp_lasts;
        logic [28:0] exp_last_addr;
        int          exp_span;
    } vec_t;

    beat_t        beat_q[$];
    logic [28:0]  exp_cmd[$];
    logic [255:0] exp_w[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_due = 0;
    int rdy_pct  = 100;
    int ordy_pct = 100;
    int rdy_low  = 0;
    bit mig_hold = 1'b0;
    bit stall_prev = 1'b0;
    logic [28:0] stall_addr = 29'd0;

    int n_acc, n_pop, n_last, n_beats;
    int first_acc, last_acc, first_beat, first_ov;
    logic [28:0] last_acc_addr;

    function automatic logic [255:0] beat_data(logic [28:0] a, int idx);
        logic [31:0] w;
        w = {a, 3'(idx)};
        return {8{w}};
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, score this cycle's handshakes, advance.
    task automatic step();
        bit give;
        beat_t b;
        logic [28:0] a;
        give = (beat_q.size() != 0) && !mig_hold && (beat_q[0].due <= cyc);
        if (give) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = beat_q[0].d;
            app_rd_data_end   = beat_q[0].e;
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data       = 256'd0;
            app_rd_data_end   = 1'b0;
        end
        if (rdy_low > 0) begin
            app_rdy = 1'b0;
            rdy_low--;
        end else begin
            app_rdy = ($urandom_range(99) < rdy_pct);
        end
        out_ready = ($urandom_range(99) < ordy_pct);
        #1;
        if (rst) begin
            exp_cmd.delete();
            exp_w.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("cmd_hold_en", app_en, 1'b1);
                check("cmd_hold_addr", app_addr, stall_addr);
            end
            if (req_valid && req_ready) begin
                for (int i = 0; i < int'(req_bursts); i++) begin
                    a = req_addr + 29'(i * 8);
                    exp_cmd.push_back(a);
                    exp_w.push_back(beat_data(a, 0));
                    exp_w.push_back(beat_data(a, 1));
                end
            end
            if (app_en && app_rdy) begin
                check("cmd_is_read", app_cmd, 3'b001);
                check("cmd_expected", exp_cmd.size() != 0, 1'b1);
                if (exp_cmd.size() != 0) begin
                    check("cmd_addr", app_addr, exp_cmd.pop_front());
                end
                b.due = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
                b.d = beat_data(app_addr, 0);
                b.e = 1'b0;
                beat_q.push_back(b);
                b.due = b.due + 1;
                b.d = beat_data(app_addr, 1);
                b.e = 1'b1;
                beat_q.push_back(b);
                last_due = b.due;
                n_acc++;
                last_acc_addr = app_addr;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                check("word_expected", exp_w.size() != 0, 1'b1);
                if (exp_w.size() != 0) begin
                    check("out_last", out_last, exp_w.size() == 1);
                    check("out_data", out_data, exp_w.pop_front());
                end
                n_pop++;
                if (out_last) n_last++;
            end
            stall_prev = app_en && !app_rdy;
            stall_addr = app_addr;
        end
        if (give) begin
            void'(beat_q.pop_front());
            n_beats++;
            if (first_beat < 0) first_beat = cyc;
        end
        @(posedge clk_ram);
        #1;
        cyc++;
    endtask

    task automatic start_request(logic [28:0] addr, int bursts);
        n_acc = 0; n_pop = 0; n_last = 0; n_beats = 0;
        first_acc = -1; last_acc = -1; first_beat = -1; first_ov = -1;
        last_acc_addr = 29'd0;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_bursts = 16'(bursts);
        step();
        req_valid  = 1'b0;
    endtask

    task automatic run_until_idle(int limit);
        int n;
        n = 0;
        while ((busy || beat_q.size() != 0 || exp_w.size() != 0) && n < limit) begin
            step();
            n++;
        end
        check("finish_in_time", n < limit, 1'b1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{29'h100,       1, 100, 100, 1,  2, 1, 29'h100,     0};
        vecs[1] = '{29'h0,         4, 100, 100, 4,  8, 1, 29'h18,      3};
        vecs[2] = '{29'h1FFFFFF8,  2, 100, 100, 2,  4, 1, 29'h0,       1};
        vecs[3] = '{29'h0,         0, 100, 100, 0,  0, 0, 29'h0,      -1};
        vecs[4] = '{29'h0ABCDE0,   5,  50,  60, 5, 10, 1, 29'h0ABCE00, -1};
        vecs[5] = '{29'h0001000,   9, 100,  30, 9, 18, 1, 29'h0001040, -1};

        // Reset state
        step();
        step();
        check("rst_app_en", app_en, 1'b0);
        check("rst_app_cmd", app_cmd, 3'b000);
        check("rst_app_addr", app_addr, 29'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        rst = 1'b0;
        step();

        // Directed table
        for (int v = 0; v < 6; v++) begin
            rdy_pct  = vecs[v].rdy_pct;
            ordy_pct = vecs[v].ordy_pct;
            start_request(vecs[v].addr, vecs[v].bursts);
            check("busy_after_req", busy, vecs[v].bursts != 0);
            run_until_idle(2000);
            check("vec_cmds", n_acc, vecs[v].exp_cmds);
            check("vec_words", n_pop, vecs[v].exp_words);
            check("vec_lasts", n_last, vecs[v].exp_lasts);
            if (vecs[v].exp_cmds > 0) check("vec_last_addr", last_acc_addr, vecs[v].exp_last_addr);
            if (vecs[v].exp_span >= 0) check("vec_b2b_span", last_acc - first_acc, vecs[v].exp_span);
            if (vecs[v].exp_words > 0) check("vec_fwft_latency", first_ov - first_beat, 1);
            check("vec_no_overflow", err_overflow, 1'b0);
            check("vec_idle", req_ready, 1'b1);
        end

        // Command stall: app_rdy low for 10 cycles after the first accept
        rdy_pct  = 100;
        ordy_pct = 100;
        start_request(29'h40, 4);
        step();
        rdy_low = 10;
        run_until_idle(2000);
        check("stall_cmds", n_acc, 4);
        check("stall_span", last_acc - first_acc, 13);
        check("stall_words", n_pop, 8);

        // Backpressure: with out_ready low issuing stops at 4 bursts
        ordy_pct = 0;
        start_request(29'h200, 20);
        for (int i = 0; i < 60; i++) step();
        check("bp_cmds_capped", n_acc, 4);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_no_overflow", err_overflow, 1'b0);
        ordy_pct = 100;
        run_until_idle(3000);
        check("bp_cmds", n_acc, 20);
        check("bp_words", n_pop, 40);
        check("bp_lasts", n_last, 1);
        check("bp_no_overflow_end", err_overflow, 1'b0);

        // Reset in DRAIN with 3 words buffered and 1 burst outstanding
        ordy_pct = 0;
        start_request(29'h300, 2);
        for (int i = 0; i < 50 && n_beats < 3; i++) step();
        mig_hold = 1'b1;
        check("rd_beats_buffered", n_beats, 3);
        check("rd_busy_before", busy, 1'b1);
        check("rd_valid_before", out_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rd_out_valid", out_valid, 1'b0);
        check("rd_busy", busy, 1'b0);
        check("rd_req_ready", req_ready, 1'b1);
        check("rd_app_en", app_en, 1'b0);
        mig_hold = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("rd_late_beat_sent", beat_q.size(), 0);
        check("rd_late_dropped", out_valid, 1'b0);
        check("rd_no_overflow", err_overflow, 1'b0);

        // Randomised requests against the model
        for (int r = 0; r < 6; r++) begin
            int nb;
            nb       = $urandom_range(12, 1);
            rdy_pct  = $urandom_range(100, 30);
            ordy_pct = $urandom_range(100, 20);
            start_request(29'($urandom), nb);
            run_until_idle(3000);
            check("rnd_cmds", n_acc, nb);
            check("rnd_words", n_pop, 2 * nb);
            check("rnd_lasts", n_last, 1);
            check("rnd_no_overflow", err_overflow, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
